wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 23 ++
 rtl/wb_stage_load_extend.sv | 33 +++
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared pipeline encodings used by the writeback stage.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC  = 2'b10,
      WB_RSV = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LS_BYTE  = 2'b00,
      LS_HALF  = 2'b01,
      LS_WORD  = 2'b10,
      LS_WORD2 = 2'b11
   } load_size_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load alignment and sign/zero extension of a raw memory word.
module load_extend
   import wb_stage_pkg::*;
#(
   parameter int DATA_SIZE = 32
) (
   input  logic [DATA_SIZE-1:0] i_data,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   input  logic [1:0]           i_off,
   output logic [DATA_SIZE-1:0] o_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // off[0] is ignored for halves
   assign byte_v = i_data[{i_off, 3'b000} +: 8];
   assign half_v = i_data[{i_off[1], 4'b0000} +: 16];

   always_comb begin
      o_data = i_data;
      unique case (i_size)
         LS_BYTE:
            o_data = {{(DATA_SIZE-8){~i_unsigned & byte_v[7]}}, byte_v};
         LS_HALF:
            o_data = {{(DATA_SIZE-16){~i_unsigned & half_v[15]}}, half_v};
         default:
            o_data = i_data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects write data, tracks halt and retired count.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int REG_SIZE  = 5,
   parameter int PC_SIZE   = 32,
   parameter int CNT_SIZE  = 32,
   parameter int LINK_REG  = 31
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_reg_write,
   input  logic [1:0]           i_wb_sel,
   input  logic [1:0]           i_load_size,
   input  logic                 i_load_unsigned,
   input  logic [1:0]           i_byte_offset,
   input  logic [DATA_SIZE-1:0] i_mem_data,
   input  logic [DATA_SIZE-1:0] i_alu_result,
   input  logic [PC_SIZE-1:0]   i_pc,
   input  logic [REG_SIZE-1:0]  i_selected_reg,
   input  logic                 i_halt,
   output logic                 o_reg_write,
   output logic [DATA_SIZE-1:0] o_selected_data,
   output logic [REG_SIZE-1:0]  o_selected_reg,
   output logic                 o_halt,
   output logic [CNT_SIZE-1:0]  o_retired
);

   localparam logic [REG_SIZE-1:0] LINK_ADDR = REG_SIZE'(LINK_REG);
   localparam logic [CNT_SIZE-1:0] CNT_MAX   = '1;

   wb_state_e             state_q, state_d;
   logic                  reg_write_q, reg_write_d;
   logic [DATA_SIZE-1:0]  data_q, data_d;
   logic [REG_SIZE-1:0]   reg_q, reg_d;
   logic [CNT_SIZE-1:0]   retired_q, retired_d;

   logic [DATA_SIZE-1:0]  load_data;
   logic [DATA_SIZE-1:0]  pc_data;
   logic [DATA_SIZE-1:0]  sel_data;
   logic [REG_SIZE-1:0]   sel_reg;
   logic                  accept;

   load_extend #(
      .DATA_SIZE (DATA_SIZE)
   ) u_load_extend (
      .i_data     (i_mem_data),
      .i_size     (i_load_size),
      .i_unsigned (i_load_unsigned),
      .i_off      (i_byte_offset),
      .o_data     (load_data)
   );

   generate
      if (PC_SIZE >= DATA_SIZE) begin : g_pc_trunc
         assign pc_data = i_pc[DATA_SIZE-1:0];
      end else begin : g_pc_zext
         assign pc_data = {{(DATA_SIZE-PC_SIZE){1'b0}}, i_pc};
      end
   endgenerate

   assign accept = i_valid & ~i_stall & ~i_flush & (state_q == ST_RUN);

   always_comb begin
      sel_data = i_alu_result;
      sel_reg  = i_selected_reg;
      unique case (i_wb_sel)
         WB_MEM: sel_data = load_data;
         WB_PC: begin
            sel_data = pc_data;
            sel_reg  = LINK_ADDR;
         end
         default: sel_data = i_alu_result;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      reg_write_d = reg_write_q;
      data_d      = data_q;
      reg_d       = reg_q;
      retired_d   = retired_q;
      // stall freezes everything; otherwise a non-write defaults to a bubble
      if (!i_stall) begin
         reg_write_d = 1'b0;
         if (accept) begin
            if (i_halt) begin
               state_d = ST_HALTED;
            end else begin
               reg_write_d = i_reg_write & (sel_reg != '0);
               data_d      = sel_data;
               reg_d       = sel_reg;
               if (retired_q != CNT_MAX) begin
                  retired_d = retired_q + CNT_SIZE'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_RUN;
         reg_write_q <= 1'b0;
         data_q      <= '0;
         reg_q       <= '0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         reg_write_q <= reg_write_d;
         data_q      <= data_d;
         reg_q       <= reg_d;
         retired_q   <= retired_d;
      end
   end

   assign o_reg_write     = reg_write_q;
   assign o_selected_data = data_q;
   assign o_selected_reg  = reg_q;
   assign o_halt          = (state_q == ST_HALTED);
   assign o_retired       = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        valid, stall, flush, rw, uns, halt;
   logic [1:0]  wsel, lsize, off;
   logic [31:0] mem, alu, pc;
   logic [4:0]  sreg;

   logic        o_we, o_we2;
   logic [31:0] o_data, o_data2;
   logic [4:0]  o_reg, o_reg2;
   logic        o_halt, o_halt2;
   logic [31:0] o_ret;
   logic [1:0]  o_ret2;

   int total = 0;
   int bad   = 0;

   // reference state
   logic        m_we, m_halt;
   logic [31:0] m_data;
   logic [4:0]  m_reg;
   logic [31:0] m_ret;
   int          m_ret2;

   wb_stage dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall),
      .i_flush(flush), .i_reg_write(rw), .i_wb_sel(wsel),
      .i_load_size(lsize), .i_load_unsigned(uns), .i_byte_offset(off),
      .i_mem_data(mem), .i_alu_result(alu), .i_pc(pc),
      .i_selected_reg(sreg), .i_halt(halt),
      .o_reg_write(o_we), .o_selected_data(o_data),
      .o_selected_reg(o_reg), .o_halt(o_halt), .o_retired(o_ret)
   );

   wb_stage #(.CNT_SIZE(2)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall),
      .i_flush(flush), .i_reg_write(rw), .i_wb_sel(wsel),
      .i_load_size(lsize), .i_load_unsigned(uns), .i_byte_offset(off),
      .i_mem_data(mem), .i_alu_result(alu), .i_pc(pc),
      .i_selected_reg(sreg), .i_halt(halt),
      .o_reg_write(o_we2), .o_selected_data(o_data2),
      .o_selected_reg(o_reg2), .o_halt(o_halt2), .o_retired(o_ret2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] load_val(
      input logic [31:0] w, input logic [1:0] sz,
      input logic u, input logic [1:0] o);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * o)) & 32'hFF;
         if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * o[1])) & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [4:0] dst;
      if (rst) begin
         m_we = 0; m_halt = 0; m_data = 0; m_reg = 0;
         m_ret = 0; m_ret2 = 0;
      end else if (!stall && !m_halt) begin
         m_we = 0;
         if (valid && !flush) begin
            if (halt) begin
               m_halt = 1;
            end else begin
               dst = (wsel == 2'd2) ? 5'd31 : sreg;
               if (wsel == 2'd1) m_data = load_val(mem, lsize, uns, off);
               else if (wsel == 2'd2) m_data = pc;
               else m_data = alu;
               m_reg = dst;
               m_we  = rw && (dst != 0);
               if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
               if (m_ret2 < 3) m_ret2 = m_ret2 + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      total++;
      if (o_we !== m_we || o_data !== m_data || o_reg !== m_reg ||
          o_halt !== m_halt || o_ret !== m_ret ||
          o_ret2 !== 2'(m_ret2) || o_we2 !== m_we ||
          o_data2 !== m_data || o_halt2 !== m_halt) begin
         bad++;
         $display("FAIL model t=%0t got we=%0b d=%h r=%0d h=%0b c=%0d c2=%0d want we=%0b d=%h r=%0d h=%0b c=%0d c2=%0d",
            $time, o_we, o_data, o_reg, o_halt, o_ret, o_ret2,
            m_we, m_data, m_reg, m_halt, m_ret, m_ret2);
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      valid = 0; stall = 0; flush = 0; rw = 0; uns = 0; halt = 0;
      wsel = 0; lsize = 2'd2; off = 0; mem = 0; alu = 0; pc = 0; sreg = 0;
   endtask

   task automatic slot(input logic [1:0] s, input logic [1:0] ls,
                       input logic u, input logic [1:0] o,
                       input logic [31:0] m, input logic [31:0] a,
                       input logic [31:0] p, input logic [4:0] r,
                       input logic h);
      idle();
      valid = 1; rw = 1; wsel = s; lsize = ls; uns = u; off = o;
      mem = m; alu = a; pc = p; sreg = r; halt = h;
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      chk("rst_we", 32'(o_we), 0);
      chk("rst_data", o_data, 0);
      chk("rst_reg", 32'(o_reg), 0);
      chk("rst_halt", 32'(o_halt), 0);
      chk("rst_ret", o_ret, 0);
      rst = 0;

      slot(2'd1, 2'd0, 0, 2'd1, 32'h1234_80FF, 0, 0, 5'd3, 0);
      step();
      chk("lb_data", o_data, 32'hFFFF_FF80);
      chk("lb_we", 32'(o_we), 1);
      chk("lb_reg", 32'(o_reg), 3);

      slot(2'd1, 2'd1, 1, 2'd2, 32'h8001_7FFF, 0, 0, 5'd4, 0);
      step();
      chk("lhu_data", o_data, 32'h0000_8001);
      slot(2'd1, 2'd1, 0, 2'd2, 32'h8001_7FFF, 0, 0, 5'd4, 0);
      step();
      chk("lh_data", o_data, 32'hFFFF_8001);

      slot(2'd2, 2'd2, 0, 2'd0, 0, 32'h5555, 32'h40, 5'd5, 0);
      step();
      chk("jal_reg", 32'(o_reg), 31);
      chk("jal_data", o_data, 32'h40);

      slot(2'd0, 2'd2, 0, 2'd0, 0, 32'h77, 0, 5'd0, 0);
      step();
      chk("r0_we", 32'(o_we), 0);
      chk("r0_ret", o_ret, 5);

      slot(2'd0, 2'd2, 0, 2'd0, 0, 32'hDEAD_BEEF, 0, 5'd7, 0);
      step();
      slot(2'd0, 2'd2, 0, 2'd0, 0, 32'h1111_2222, 0, 5'd9, 0);
      stall = 1; flush = 1;
      step();
      step();
      chk("stall_we", 32'(o_we), 1);
      chk("stall_data", o_data, 32'hDEAD_BEEF);
      chk("stall_reg", 32'(o_reg), 7);
      chk("stall_ret", o_ret, 6);
      stall = 0;
      step();
      chk("flush_we", 32'(o_we), 0);
      chk("flush_data", o_data, 32'hDEAD_BEEF);
      chk("flush_ret", o_ret, 6);
      chk("sat_ret2", 32'(o_ret2), 3);

      idle();
      rst = 1;
      #1;
      chk("async_ret", o_ret, 0);
      step();
      rst = 0;
      for (int i = 1; i <= 3; i++) begin
         slot(2'd0, 2'd2, 0, 2'd0, 0, 32'(i * 16), 0, 5'(i), 0);
         step();
      end
      slot(2'd0, 2'd2, 0, 2'd0, 0, 32'h99, 0, 5'd4, 1);
      step();
      chk("halt_flag", 32'(o_halt), 1);
      chk("halt_we", 32'(o_we), 0);
      chk("halt_ret", o_ret, 3);
      slot(2'd0, 2'd2, 0, 2'd0, 0, 32'hAA, 0, 5'd6, 0);
      step();
      chk("halted_we", 32'(o_we), 0);
      chk("halted_ret", o_ret, 3);
      chk("halted_flag", 32'(o_halt), 1);
      idle();
      rst = 1;
      step();
      rst = 0;
      chk("rst2_halt", 32'(o_halt), 0);
      chk("rst2_data", o_data, 0);
      chk("rst2_ret", o_ret, 0);

      for (int n = 0; n < 600; n++) begin
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 6) == 0);
         rw    = $urandom_range(0, 1);
         wsel  = 2'($urandom_range(0, 3));
         lsize = 2'($urandom_range(0, 3));
         uns   = $urandom_range(0, 1);
         off   = 2'($urandom_range(0, 3));
         mem   = $urandom;
         alu   = $urandom;
         pc    = $urandom;
         sreg  = 5'($urandom_range(0, 31));
         halt  = ($urandom_range(0, 40) == 0);
         rst   = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 0;
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
